// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Widths, NOP encoding and FSM state codes used by if_fetch_unit and if_fetch_fifo.
package if_fetch_unit_pkg;

   localparam int unsigned IF_PC_WIDTH   = 32;
   localparam int unsigned IF_INST_WIDTH = 32;
   localparam logic [31:0] INST_NOP      = 32'h0000_0013;
   localparam logic [31:0] IF_RESET_PC   = 32'h0000_0000;
   localparam int unsigned IF_FIFO_DEPTH = 2;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   // Sequential fetch step; wraps silently at the top of the address space.
   function automatic logic [IF_PC_WIDTH-1:0] next_fetch_pc(input logic [IF_PC_WIDTH-1:0] cur);
      return cur + IF_PC_WIDTH'(4);
   endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO with synchronous clear and same-cycle push/pop (also when full).
// Head entry is visible combinationally; count reports occupancy.
module if_fetch_fifo
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == CW'(DEPTH));
      count     = count_q;
      head_data = mem_q[rd_ptr_q];
      do_pop    = pop && !empty;
      do_push   = push && (!full || do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset; validity is tracked entirely by count_q.
   always_ff @(posedge clk) begin
      if (do_push && !clear && !reset) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: in-order imem requests, prefetch FIFO, redirect with stale drain.
// Optional macro IF_PERF_CNT_EN adds perf_inst_cnt / perf_flush_cnt output counters.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned PC_WIDTH        = IF_PC_WIDTH,
   parameter int unsigned INST_WIDTH      = IF_INST_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(IF_RESET_PC),
   parameter int unsigned FIFO_DEPTH      = IF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [PC_WIDTH-1:0]   imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [INST_WIDTH-1:0] imem_rsp_data,
   output logic [PC_WIDTH-1:0]   pc,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  fetch_valid,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]           perf_inst_cnt,
   output logic [31:0]           perf_flush_cnt,
`endif
   output logic                  IF_flush
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned DW = PC_WIDTH + INST_WIDTH;
   localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]       inflight_q, inflight_d;
   logic [CW-1:0]       stale_cnt_q, stale_cnt_d;
   logic [0:0]          state_q, state_d;

   logic                req_fire;
   logic                rsp_stale;
   logic                rsp_live;
   logic                do_pop;
   logic [CW:0]         used;

   logic [DW-1:0]       data_head;
   logic                data_empty;
   logic                data_full;
   logic [CW-1:0]       data_count;
   logic [PC_WIDTH-1:0] tag_head;
   logic                tag_empty;
   logic                tag_full;
   logic [CW-1:0]       tag_count;
   logic                unused_fifo_flags;

   assign unused_fifo_flags = ^{data_full, tag_full, tag_count, tag_empty};

   // Data FIFO holds {pc_tag, inst}; redirect clears both FIFOs.
   if_fetch_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_data_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (redirect_valid),
      .push      (rsp_live),
      .push_data ({tag_head, imem_rsp_data}),
      .pop       (do_pop),
      .head_data (data_head),
      .empty     (data_empty),
      .full      (data_full),
      .count     (data_count)
   );

   if_fetch_fifo #(
      .WIDTH (PC_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (redirect_valid),
      .push      (req_fire),
      .push_data (fetch_pc_q),
      .pop       (rsp_live),
      .head_data (tag_head),
      .empty     (tag_empty),
      .full      (tag_full),
      .count     (tag_count)
   );

   always_comb begin
      used           = {1'b0, data_count} + {1'b0, inflight_q};
      imem_req_valid = !reset && !redirect_valid && (used < DEPTH_LIM);
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;

      rsp_stale = imem_rsp_valid && (state_q == ST_DRAIN);
      rsp_live  = imem_rsp_valid && (state_q == ST_RUN) && !reset;
      do_pop    = !data_empty && !stall && !redirect_valid && !reset;

      fetch_pc_d = req_fire ? next_fetch_pc(fetch_pc_q) : fetch_pc_q;
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
      stale_cnt_d = rsp_stale ? stale_cnt_q - CW'(1) : stale_cnt_q;
      if (redirect_valid) begin
         // Every request still outstanding after this cycle belongs to the old path.
         fetch_pc_d  = redirect_pc;
         stale_cnt_d = inflight_d;
      end
      state_d = (stale_cnt_d != '0) ? ST_DRAIN : ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q  <= RESET_PC;
         inflight_q  <= '0;
         stale_cnt_q <= '0;
         state_q     <= ST_RUN;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         inflight_q  <= inflight_d;
         stale_cnt_q <= stale_cnt_d;
         state_q     <= state_d;
      end
   end

   always_comb begin
      if (reset || data_empty) begin
         pc   = '0;
         inst = INST_WIDTH'(INST_NOP);
      end else begin
         pc   = data_head[DW-1:INST_WIDTH];
         inst = data_head[INST_WIDTH-1:0];
      end
      fetch_valid = !reset && !data_empty && !redirect_valid;
      IF_flush    = !reset && redirect_valid;
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_inst_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_inst_q  <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_inst_q  <= perf_inst_q + 32'(do_pop);
         perf_flush_q <= perf_flush_q + 32'(redirect_valid);
      end
   end

   assign perf_inst_cnt  = perf_inst_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: queue-based fetch model plus an in-order memory responder.
// Random stall/ready/redirect/latency traffic follows directed scenarios with literal pins.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        fetch_valid;
   logic        IF_flush;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_inst_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   if_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .pc             (pc),
      .inst           (inst),
      .fetch_valid    (fetch_valid),
`ifdef IF_PERF_CNT_EN
      .perf_inst_cnt  (perf_inst_cnt),
      .perf_flush_cnt (perf_flush_cnt),
`endif
      .IF_flush       (IF_flush)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int lat    = 1;

   // Memory responder: accepted requests, returned in order once due.
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   // Reference model: plain queues and counters.
   logic [31:0] m_pc;
   logic [31:0] m_fq_pc[$];
   logic [31:0] m_fq_inst[$];
   logic [31:0] m_tags[$];
   int          m_inflight;
   int          m_stale;

   // Capture of delivered (popped) instructions for literal pins.
   int          cap_want = 0;
   int          cap_n    = 0;
   logic [31:0] cap_pc[4];
   logic [31:0] cap_inst[4];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic check_and_model();
      logic        e_req;
      logic        e_empty;
      logic [31:0] tag;
      if (reset) begin
         chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
         chk("rst_pc", pc, 32'd0);
         chk("rst_inst", inst, NOP);
         chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
         chk("rst_flush", 32'(IF_flush), 32'd0);
         m_pc = 32'd0;
         m_fq_pc.delete();
         m_fq_inst.delete();
         m_tags.delete();
         m_inflight = 0;
         m_stale = 0;
         mq_addr.delete();
         mq_due.delete();
         return;
      end
      e_req   = !redirect_valid && ((m_fq_pc.size() + m_inflight) < DEPTH);
      e_empty = (m_fq_pc.size() == 0);
      chk("req_valid", 32'(imem_req_valid), 32'(e_req));
      if (e_req) chk("req_addr", imem_req_addr, m_pc);
      chk("pc", pc, e_empty ? 32'd0 : m_fq_pc[0]);
      chk("inst", inst, e_empty ? NOP : m_fq_inst[0]);
      chk("fetch_valid", 32'(fetch_valid), 32'(!e_empty && !redirect_valid));
      chk("if_flush", 32'(IF_flush), 32'(redirect_valid));

      if (!e_empty && !stall && !redirect_valid) begin
         if (cap_n < cap_want) begin
            cap_pc[cap_n]   = pc;
            cap_inst[cap_n] = inst;
            cap_n++;
         end
         void'(m_fq_pc.pop_front());
         void'(m_fq_inst.pop_front());
      end
      if (imem_rsp_valid) begin
         m_inflight--;
         if (m_stale > 0) begin
            m_stale--;
         end else begin
            tag = (m_tags.size() > 0) ? m_tags.pop_front() : 32'hxxxx_xxxx;
            m_fq_pc.push_back(tag);
            m_fq_inst.push_back(imem_rsp_data);
         end
      end
      if (e_req && imem_req_ready) begin
         m_tags.push_back(m_pc);
         m_pc = m_pc + 32'd4;
         m_inflight++;
      end
      if (redirect_valid) begin
         m_fq_pc.delete();
         m_fq_inst.delete();
         m_tags.delete();
         m_stale = m_inflight;
         m_pc = redirect_pc;
      end
   endtask

   task automatic step();
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
      check_and_model();
      if (!reset && imem_req_valid && imem_req_ready) begin
         mq_addr.push_back(imem_req_addr);
         mq_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic capture(input int want, input int max_cycles);
      for (int k = 0; k < 4; k++) begin
         cap_pc[k]   = 32'hDEAD_BEEF;
         cap_inst[k] = 32'hDEAD_BEEF;
      end
      cap_n    = 0;
      cap_want = want;
      for (int i = 0; i < max_cycles && cap_n < want; i++) step();
      cap_want = 0;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      @(posedge clk);
      #1;
      repeat (3) step();
      reset = 1'b0;
      #1;
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, 32'h0);

      // Sequential fetch with 1-cycle memory.
      lat = 1;
      capture(3, 30);
      chk("seq_pc0", cap_pc[0], 32'h0);
      chk("seq_inst0", cap_inst[0], mem_word(32'h0));
      chk("seq_pc1", cap_pc[1], 32'h4);
      chk("seq_pc2", cap_pc[2], 32'h8);
      repeat (6) step();

      // Stall with the prefetch buffer filling up.
      stall = 1'b1;
      repeat (3) step();
      stall = 1'b0;
      repeat (4) step();

      // Redirect with requests in flight.
      lat = 3;
      repeat (6) step();
      do_redirect(32'h100);
      capture(2, 40);
      chk("redir_pc0", cap_pc[0], 32'h100);
      chk("redir_inst0", cap_inst[0], mem_word(32'h100));
      chk("redir_pc1", cap_pc[1], 32'h104);

      // Back-to-back redirects with slow memory.
      lat = 4;
      repeat (5) step();
      do_redirect(32'h100);
      do_redirect(32'h200);
      capture(2, 60);
      chk("b2b_pc0", cap_pc[0], 32'h200);
      chk("b2b_pc1", cap_pc[1], 32'h204);

      // Memory not ready for 5 cycles.
      lat = 2;
      imem_req_ready = 1'b0;
      repeat (5) step();
      imem_req_ready = 1'b1;
      repeat (6) step();

      // Address wrap.
      lat = 1;
      do_redirect(32'hFFFF_FFFC);
      capture(2, 40);
      chk("wrap_pc0", cap_pc[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", cap_pc[1], 32'h0);
      chk("wrap_inst1", cap_inst[1], mem_word(32'h0));

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if ((i % 50) == 0) lat = int'($urandom_range(1, 4));
         stall          = ($urandom_range(0, 3) == 0);
         imem_req_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = {$urandom} & 32'hFFFF_FFFC;
         end else begin
            redirect_valid = 1'b0;
         end
         step();
      end
      redirect_valid = 1'b0;
      stall = 1'b0;
      imem_req_ready = 1'b1;

      // Reset mid-stream.
      lat = 2;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("post_rst_req_addr", imem_req_addr, 32'h0);
      chk("post_rst_fetch_valid", 32'(fetch_valid), 32'd0);
      capture(1, 30);
      chk("post_rst_pc0", cap_pc[0], 32'h0);
      repeat (5) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
